rtos_list_sched_core: RTL and testbench

// - RTOS hardware kernel core: per-task table (TCB address, priority, state) holding ready, delayed and blocked lists.
// - Built-in scheduler picks the running task on each tick and presents its TCB address to the CPU-side interface.
// - Sits between the AXI command decoder (create/resume/suspend/delay/semaphore strobes) and the context-switch IRQ logic.

---
 rtl/rtos_pkg.sv | 26 ++
 rtl/rtos_tick_scheduler.sv | 58 +++++
 rtl/rtos_list_sched_core.sv | 160 ++++++++++++++++
 tb/tb_rtos_list_sched_core.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rtos_pkg.sv
// Shared definitions for the RTOS list scheduler core.
// Holds the table dimensions, the "no task" id, the per-slot task state
// encoding and a helper that range-checks a task id against the table size.
package rtos_pkg;

  localparam int NTASK  = 16;
  localparam int PRIO_W = 6;
  localparam int ID_W   = 8;
  localparam int IDX_W  = $clog2(NTASK);

  localparam logic [ID_W-1:0] ID_NONE = 8'hFF;

  typedef enum logic [2:0] {
    ST_FREE,
    ST_READY,
    ST_DELAYED,
    ST_SUSPENDED,
    ST_BLOCKED
  } task_state_e;

  // Ids at or above NTASK (including ID_NONE) do not name a slot.
  function automatic logic id_valid(input logic [ID_W-1:0] id);
    return id < ID_W'(NTASK);
  endfunction

endpackage

// File: rtl/rtos_tick_scheduler.sv
// Tick-driven context-switch stage.
// Detects the rising edge of the tick request, chooses the next running task
// (pre-empt to the top READY task, otherwise round-robin within the top
// priority) and registers the running id / TCB address with a one-cycle pulse.
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   tick                     level tick request, rising edge used
//   cur_ready, cur_prio      whether the running task is READY, and its priority
//   top_prio                 highest READY priority
//   hpri_id, hpri_tcb        top READY task and its TCB address (0 if none)
//   next_id, next_tcb        round-robin successor and its TCB address (0 if none)
//   switch_pulse             one-cycle pulse per tick edge
//   run_tcb, run_id          running task TCB address / id
module rtos_tick_scheduler
  import rtos_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              cur_ready,
  input  logic [PRIO_W-1:0] cur_prio,
  input  logic [PRIO_W-1:0] top_prio,
  input  logic [ID_W-1:0]   hpri_id,
  input  logic [31:0]       hpri_tcb,
  input  logic [ID_W-1:0]   next_id,
  input  logic [31:0]       next_tcb,
  output logic              switch_pulse,
  output logic [31:0]       run_tcb,
  output logic [ID_W-1:0]   run_id
);

  logic tick_q;
  logic tick_edge;
  logic take_hpri;

  assign tick_edge = tick & ~tick_q;
  // Pre-empt when the running task left READY or something strictly better exists.
  assign take_hpri = !cur_ready || (top_prio > cur_prio);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q       <= 1'b0;
      switch_pulse <= 1'b0;
      run_tcb      <= '0;
      run_id       <= ID_NONE;
    end else begin
      tick_q       <= tick;
      switch_pulse <= tick_edge;
      if (tick_edge) begin
        run_id  <= take_hpri ? hpri_id  : next_id;
        run_tcb <= take_hpri ? hpri_tcb : next_tcb;
      end
    end
  end

endmodule

// File: rtl/rtos_list_sched_core.sv
// RTOS hardware kernel core: per-task table (TCB address, priority, state,
// wake time), command decode, delay expiry and a combinational READY scan,
// feeding the tick scheduler that presents the running task to the CPU side.
// Ports:
//   aclk, aresetn                clock; synchronous active-high reset
//   insnew/ins/susp/ins_dly      create/resume/suspend/delay idtask_in
//   resume_tasktimer_in          early wake of idtasktimer_in
//   suspend/resume_semaphoretask block/unblock id_semaphoretask_in
//   tickval_in, tick_in          system tick count and tick request
//   highpriority_out, ptr_*      combinational READY scan results
//   tick_out, addrTCB_out, id_task_out  registered context-switch outputs
module rtos_list_sched_core
  import rtos_pkg::*;
(
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              insnew_rdylist_in,
  input  logic [31:0]       addrtcb_in,
  input  logic [PRIO_W-1:0] priority_in,
  input  logic              ins_rdylist_in,
  input  logic              susp_rdylist_in,
  input  logic              ins_dlylist_in,
  input  logic [ID_W-1:0]   idtask_in,
  input  logic [31:0]       valdelay_in,
  input  logic              resume_tasktimer_in,
  input  logic [ID_W-1:0]   idtasktimer_in,
  input  logic              suspend_semaphoretask_in,
  input  logic              resume_semaphoretask_in,
  input  logic [ID_W-1:0]   id_semaphoretask_in,
  input  logic [31:0]       tickval_in,
  input  logic              tick_in,
  output logic [PRIO_W-1:0] highpriority_out,
  output logic [ID_W-1:0]   ptr_hpritask_out,
  output logic [ID_W-1:0]   ptr_nexttask_out,
  output logic              tick_out,
  output logic [31:0]       addrTCB_out,
  output logic [ID_W-1:0]   id_task_out
);

  task_state_e       state_q [NTASK];
  logic [31:0]       tcb_q   [NTASK];
  logic [PRIO_W-1:0] prio_q  [NTASK];
  logic [31:0]       wake_q  [NTASK];

  logic [NTASK-1:0] expired;
  logic [IDX_W-1:0] t_idx, tm_idx, sem_idx, cur_idx, hpri_idx, next_idx;

  assign t_idx    = idtask_in[IDX_W-1:0];
  assign tm_idx   = idtasktimer_in[IDX_W-1:0];
  assign sem_idx  = id_semaphoretask_in[IDX_W-1:0];
  assign cur_idx  = id_task_out[IDX_W-1:0];
  assign hpri_idx = ptr_hpritask_out[IDX_W-1:0];
  assign next_idx = ptr_nexttask_out[IDX_W-1:0];

  // Wrap-safe: the tick counter has reached wake when the 32-bit difference is non-negative.
  always_comb begin
    for (int i = 0; i < NTASK; i++)
      expired[i] = (state_q[i] == ST_DELAYED) && ($signed(tickval_in - wake_q[i]) >= 0);
  end

  always_ff @(posedge aclk) begin
    if (aresetn) begin
      // NOTE: the whole table is cleared, not only the state field, so a
      // reset mid-run leaves no stale TCB, priority or wake value behind.
      for (int i = 0; i < NTASK; i++) begin
        state_q[i] <= ST_FREE;
        tcb_q[i]   <= '0;
        prio_q[i]  <= '0;
        wake_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NTASK; i++)
        if (expired[i]) state_q[i] <= ST_READY;

      // Single command per cycle, fixed priority. Assigned after the expiry
      // loop so a command to an expiring slot overrides the wake-up.
      if (insnew_rdylist_in) begin
        if (id_valid(idtask_in)) begin
          state_q[t_idx] <= ST_READY;
          tcb_q[t_idx]   <= addrtcb_in;
          prio_q[t_idx]  <= priority_in;
        end
      end else if (ins_rdylist_in) begin
        if (id_valid(idtask_in) && state_q[t_idx] == ST_SUSPENDED)
          state_q[t_idx] <= ST_READY;
      end else if (susp_rdylist_in) begin
        if (id_valid(idtask_in) && state_q[t_idx] != ST_FREE)
          state_q[t_idx] <= ST_SUSPENDED;
      end else if (ins_dlylist_in) begin
        if (id_valid(idtask_in) && state_q[t_idx] == ST_READY) begin
          state_q[t_idx] <= ST_DELAYED;
          wake_q[t_idx]  <= tickval_in + valdelay_in;
        end
      end else if (resume_tasktimer_in) begin
        if (id_valid(idtasktimer_in) && state_q[tm_idx] == ST_DELAYED)
          state_q[tm_idx] <= ST_READY;
      end else if (suspend_semaphoretask_in) begin
        if (id_valid(id_semaphoretask_in) && state_q[sem_idx] == ST_READY)
          state_q[sem_idx] <= ST_BLOCKED;
      end else if (resume_semaphoretask_in) begin
        if (id_valid(id_semaphoretask_in) && state_q[sem_idx] == ST_BLOCKED)
          state_q[sem_idx] <= ST_READY;
      end
    end
  end

  // Top READY priority; strict '>' keeps the lowest id on ties.
  // NOTE: blocking assignments here model a sequential scan that settles
  // combinationally; every output gets a default first so no latch forms.
  always_comb begin
    highpriority_out = '0;
    ptr_hpritask_out = ID_NONE;
    for (int i = 0; i < NTASK; i++) begin
      if (state_q[i] == ST_READY &&
          (ptr_hpritask_out == ID_NONE || prio_q[i] > highpriority_out)) begin
        highpriority_out = prio_q[i];
        ptr_hpritask_out = ID_W'(i);
      end
    end
  end

  // Round-robin successor: first READY slot at the top priority after the
  // running one, wrapping back to the running slot last. With no running
  // task the search starts at slot 0.
  always_comb begin
    int base;
    base = id_valid(id_task_out) ? int'(cur_idx) : NTASK - 1;
    ptr_nexttask_out = ID_NONE;
    for (int k = 1; k <= NTASK; k++) begin
      if (ptr_nexttask_out == ID_NONE &&
          state_q[(base + k) % NTASK] == ST_READY &&
          prio_q[(base + k) % NTASK] == highpriority_out)
        ptr_nexttask_out = ID_W'((base + k) % NTASK);
    end
  end

  logic        cur_ready;
  logic [31:0] hpri_tcb, next_tcb;

  assign cur_ready = id_valid(id_task_out) && state_q[cur_idx] == ST_READY;
  assign hpri_tcb  = (ptr_hpritask_out == ID_NONE) ? 32'h0 : tcb_q[hpri_idx];
  assign next_tcb  = (ptr_nexttask_out == ID_NONE) ? 32'h0 : tcb_q[next_idx];

  rtos_tick_scheduler u_sched (
    .clk          (aclk),
    .rst          (aresetn),
    .tick         (tick_in),
    .cur_ready    (cur_ready),
    .cur_prio     (prio_q[cur_idx]),
    .top_prio     (highpriority_out),
    .hpri_id      (ptr_hpritask_out),
    .hpri_tcb     (hpri_tcb),
    .next_id      (ptr_nexttask_out),
    .next_tcb     (next_tcb),
    .switch_pulse (tick_out),
    .run_tcb      (addrTCB_out),
    .run_id       (id_task_out)
  );

endmodule

// File: tb/tb_rtos_list_sched_core.sv
// Self-checking bench for rtos_list_sched_core. Context-switch expectations
// are queued when a tick is issued and compared by a monitor whenever the
// DUT pulses tick_out; READY-scan outputs are compared directly.
module tb_rtos_list_sched_core;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        insnew_rdylist_in, ins_rdylist_in, susp_rdylist_in, ins_dlylist_in;
  logic [31:0] addrtcb_in, valdelay_in, tickval_in;
  logic [5:0]  priority_in;
  logic [7:0]  idtask_in, idtasktimer_in, id_semaphoretask_in;
  logic        resume_tasktimer_in, suspend_semaphoretask_in, resume_semaphoretask_in;
  logic        tick_in;
  logic [5:0]  highpriority_out;
  logic [7:0]  ptr_hpritask_out, ptr_nexttask_out, id_task_out;
  logic        tick_out;
  logic [31:0] addrTCB_out;

  rtos_list_sched_core dut (
    .aclk(aclk), .aresetn(aresetn),
    .insnew_rdylist_in(insnew_rdylist_in), .addrtcb_in(addrtcb_in), .priority_in(priority_in),
    .ins_rdylist_in(ins_rdylist_in), .susp_rdylist_in(susp_rdylist_in),
    .ins_dlylist_in(ins_dlylist_in), .idtask_in(idtask_in), .valdelay_in(valdelay_in),
    .resume_tasktimer_in(resume_tasktimer_in), .idtasktimer_in(idtasktimer_in),
    .suspend_semaphoretask_in(suspend_semaphoretask_in),
    .resume_semaphoretask_in(resume_semaphoretask_in),
    .id_semaphoretask_in(id_semaphoretask_in), .tickval_in(tickval_in), .tick_in(tick_in),
    .highpriority_out(highpriority_out), .ptr_hpritask_out(ptr_hpritask_out),
    .ptr_nexttask_out(ptr_nexttask_out), .tick_out(tick_out),
    .addrTCB_out(addrTCB_out), .id_task_out(id_task_out)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [7:0]  id;
    logic [31:0] addr;
  } sw_exp_t;

  sw_exp_t sb_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every tick_out pulse must match the oldest queued expectation.
  initial begin
    sw_exp_t e;
    forever begin
      @(negedge aclk);
      if (tick_out === 1'b1) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_tick: got id %h addr %h expected no pulse", id_task_out, addrTCB_out);
        end else begin
          e = sb_q.pop_front();
          check("tick_id", {24'h0, id_task_out}, {24'h0, e.id});
          check("tick_addr", addrTCB_out, e.addr);
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic create(input logic [7:0] id, input logic [31:0] tcb, input logic [5:0] pri);
    idtask_in = id; addrtcb_in = tcb; priority_in = pri; insnew_rdylist_in = 1'b1;
    step();
    insnew_rdylist_in = 1'b0;
  endtask

  task automatic cmd_resume(input logic [7:0] id);
    idtask_in = id; ins_rdylist_in = 1'b1; step(); ins_rdylist_in = 1'b0;
  endtask

  task automatic cmd_susp(input logic [7:0] id);
    idtask_in = id; susp_rdylist_in = 1'b1; step(); susp_rdylist_in = 1'b0;
  endtask

  task automatic cmd_delay(input logic [7:0] id, input logic [31:0] dly);
    idtask_in = id; valdelay_in = dly; ins_dlylist_in = 1'b1; step(); ins_dlylist_in = 1'b0;
  endtask

  task automatic cmd_timer_wake(input logic [7:0] id);
    idtasktimer_in = id; resume_tasktimer_in = 1'b1; step(); resume_tasktimer_in = 1'b0;
  endtask

  task automatic cmd_sem(input logic [7:0] id, input logic block);
    id_semaphoretask_in = id;
    suspend_semaphoretask_in = block;
    resume_semaphoretask_in  = ~block;
    step();
    suspend_semaphoretask_in = 1'b0;
    resume_semaphoretask_in  = 1'b0;
  endtask

  task automatic do_tick(input logic [7:0] id, input logic [31:0] addr);
    sb_q.push_back('{id: id, addr: addr});
    tick_in = 1'b1; step();
    tick_in = 1'b0; step();
  endtask

  task automatic chk_scan(input string name, input logic [5:0] hp, input logic [7:0] hid);
    check({name, "_hp"}, {26'h0, highpriority_out}, {26'h0, hp});
    check({name, "_hid"}, {24'h0, ptr_hpritask_out}, {24'h0, hid});
  endtask

  task automatic chk_reset(input string name);
    check({name, "_hp"}, {26'h0, highpriority_out}, 32'h0);
    check({name, "_hid"}, {24'h0, ptr_hpritask_out}, 32'hFF);
    check({name, "_nid"}, {24'h0, ptr_nexttask_out}, 32'hFF);
    check({name, "_tick"}, {31'h0, tick_out}, 32'h0);
    check({name, "_addr"}, addrTCB_out, 32'h0);
    check({name, "_id"}, {24'h0, id_task_out}, 32'hFF);
  endtask

  initial begin
    aresetn = 1'b1;
    insnew_rdylist_in = 0; ins_rdylist_in = 0; susp_rdylist_in = 0; ins_dlylist_in = 0;
    resume_tasktimer_in = 0; suspend_semaphoretask_in = 0; resume_semaphoretask_in = 0;
    addrtcb_in = 0; valdelay_in = 0; tickval_in = 0; priority_in = 0;
    idtask_in = 0; idtasktimer_in = 0; id_semaphoretask_in = 0; tick_in = 0;
    step(); step();
    aresetn = 1'b0;
    step();
    chk_reset("reset");

    // Two equal-priority tasks; lowest id wins the scan.
    create(8'd1, 32'hBBBBBBBB, 6'h2A);
    chk_scan("create1", 6'h2A, 8'd1);
    create(8'd2, 32'hCCCCCCCC, 6'h2A);
    chk_scan("create2", 6'h2A, 8'd1);
    check("next_idle", {24'h0, ptr_nexttask_out}, 32'd1);

    // Round-robin alternation.
    do_tick(8'd1, 32'hBBBBBBBB);
    check("next_after1", {24'h0, ptr_nexttask_out}, 32'd2);
    do_tick(8'd2, 32'hCCCCCCCC);
    do_tick(8'd1, 32'hBBBBBBBB);
    do_tick(8'd2, 32'hCCCCCCCC);

    // Pre-emption by a higher priority, then fall back after suspend.
    create(8'd3, 32'hDDDDDDDD, 6'h30);
    chk_scan("create3", 6'h30, 8'd3);
    do_tick(8'd3, 32'hDDDDDDDD);
    cmd_susp(8'd3);
    chk_scan("susp3", 6'h2A, 8'd1);
    do_tick(8'd1, 32'hBBBBBBBB);
    do_tick(8'd2, 32'hCCCCCCCC);

    // Delay id1 by 0x10 at tickval 5: wake at 21.
    tickval_in = 32'd5;
    cmd_delay(8'd1, 32'h10);
    chk_scan("dly_start", 6'h2A, 8'd2);
    for (int t = 6; t <= 20; t++) begin
      tickval_in = t;
      step();
    end
    chk_scan("dly_t20", 6'h2A, 8'd2);
    tickval_in = 32'd21;
    step();
    chk_scan("dly_t21", 6'h2A, 8'd1);

    // Zero delay: READY again one cycle later.
    tickval_in = 32'd50;
    cmd_delay(8'd1, 32'h0);
    chk_scan("dly0_held", 6'h2A, 8'd2);
    step();
    chk_scan("dly0_ready", 6'h2A, 8'd1);

    // Wake time across the 32-bit wrap.
    tickval_in = 32'hFFFF_FFF0;
    cmd_delay(8'd1, 32'h20);
    tickval_in = 32'hFFFF_FFF8;
    step();
    chk_scan("wrap_pending", 6'h2A, 8'd2);
    tickval_in = 32'h10;
    step();
    chk_scan("wrap_ready", 6'h2A, 8'd1);

    // Early wake via the timer interface.
    tickval_in = 32'd100;
    cmd_delay(8'd1, 32'd1000);
    chk_scan("early_held", 6'h2A, 8'd2);
    cmd_timer_wake(8'd1);
    chk_scan("early_wake", 6'h2A, 8'd1);

    // Expiry and suspend to the same slot in one cycle: suspend wins.
    cmd_delay(8'd1, 32'h0);
    cmd_susp(8'd1);
    chk_scan("collide", 6'h2A, 8'd2);
    cmd_resume(8'd1);
    chk_scan("collide_resume", 6'h2A, 8'd1);

    // Semaphore block of the only READY task.
    cmd_susp(8'd2);
    cmd_sem(8'd1, 1'b1);
    chk_scan("sem_block", 6'h00, 8'hFF);
    check("sem_block_nid", {24'h0, ptr_nexttask_out}, 32'hFF);
    do_tick(8'hFF, 32'h0);
    cmd_sem(8'd1, 1'b0);
    chk_scan("sem_wake", 6'h2A, 8'd1);
    cmd_resume(8'd2);

    // Out-of-range id is ignored.
    create(8'd16, 32'h12345678, 6'h3F);
    chk_scan("bad_id", 6'h2A, 8'd1);

    // Create together with lower-priority commands: only the create applies.
    idtask_in = 8'd4; addrtcb_in = 32'hEEEEEEEE; priority_in = 6'h3F;
    id_semaphoretask_in = 8'd1;
    insnew_rdylist_in = 1'b1; susp_rdylist_in = 1'b1; suspend_semaphoretask_in = 1'b1;
    step();
    insnew_rdylist_in = 1'b0; susp_rdylist_in = 1'b0; suspend_semaphoretask_in = 1'b0;
    chk_scan("same_cycle", 6'h3F, 8'd4);
    cmd_susp(8'd4);
    chk_scan("same_cycle_id1", 6'h2A, 8'd1);

    // Reset mid-run clears table and outputs.
    do_tick(8'd1, 32'hBBBBBBBB);
    aresetn = 1'b1;
    step();
    aresetn = 1'b0;
    step();
    chk_reset("midreset");
    do_tick(8'hFF, 32'h0);

    repeat (3) step();
    check("sb_drained", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
